tagv_write_ctrl: RTL and testbench



---
 rtl/cache_pkg.sv | 29 ++
 rtl/tagv_sweep_cnt.sv | 31 +++
 rtl/tagv_write_ctrl.sv | 120 ++++++++++++
 tb/tb_tagv_write_ctrl.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared cache definitions for the tag/valid write path.
// - TAGV_W / TAGV_VALID_BIT: layout of a tagv RAM word ({tag, valid}, valid in bit 0)
// - tagv_state_t: write-controller FSM states
// - tagv_word(): packs a tag and valid bit into a tagv word
package cache_pkg;

  localparam int unsigned TAG_WIDTH_DEFAULT = 20;
  localparam int unsigned TAGV_W            = TAG_WIDTH_DEFAULT + 1;
  localparam int unsigned TAGV_VALID_BIT    = 0;

  // The pack helper works on a wide word so it serves any TAG_WIDTH up to
  // TAGV_TAG_MAX; callers size-cast the argument in and the result back out.
  localparam int unsigned TAGV_PACK_W  = 64;
  localparam int unsigned TAGV_TAG_MAX = TAGV_PACK_W - 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    ACK   = 2'd2
  } tagv_state_t;

  function automatic logic [TAGV_PACK_W-1:0] tagv_word(
    input logic [TAGV_TAG_MAX-1:0] tag,
    input logic                    valid
  );
    return {tag, valid};
  endfunction

endpackage

// File: rtl/tagv_sweep_cnt.sv
// Set-index counter for the IBAR invalidate-all sweep.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   start    : clear the counter to 0 (takes priority over en)
//   en       : advance the counter by one
//   count    : current sweep index
//   last     : count is at the final set index
module tagv_sweep_cnt #(
  parameter int unsigned ADDR_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  en,
  output logic [ADDR_WIDTH-1:0] count,
  output logic                  last
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (start) begin
      count <= '0;
    end else if (en) begin
      count <= count + ADDR_WIDTH'(1);
    end
  end

  assign last = (count == '1);

endmodule

// File: rtl/tagv_write_ctrl.sv
// Write-side controller for the cache tag/valid RAM. Owns the single tagv
// write port and arbitrates refill (tag install) > CACOP index-invalidate >
// IBAR invalidate-all. IBAR sweeps one set per cycle with all ways enabled.
// Ports:
//   clk, rst                      : clock, asynchronous active-high reset
//   ibar_req / ibar_ack           : invalidate-all level request / 1-cycle done pulse
//   refill_req/idx/way/tag        : install request, refill_ready = accept
//   cacop_req/idx/way             : single-line invalidate, cacop_ready = accept
//   busy                          : sweep in progress, lookup must stall
//   tagv_we / tagv_waddr / tagv_din : registered RAM write port ({tag, valid})
module tagv_write_ctrl
  import cache_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 6,
  parameter int unsigned TAG_WIDTH  = 20,
  parameter int unsigned WAYS       = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ibar_req,
  output logic                     ibar_ack,
  input  logic                     refill_req,
  input  logic [ADDR_WIDTH-1:0]    refill_idx,
  input  logic [$clog2(WAYS)-1:0]  refill_way,
  input  logic [TAG_WIDTH-1:0]     refill_tag,
  output logic                     refill_ready,
  input  logic                     cacop_req,
  input  logic [ADDR_WIDTH-1:0]    cacop_idx,
  input  logic [$clog2(WAYS)-1:0]  cacop_way,
  output logic                     cacop_ready,
  output logic                     busy,
  output logic [WAYS-1:0]          tagv_we,
  output logic [ADDR_WIDTH-1:0]    tagv_waddr,
  output logic [TAG_WIDTH:0]       tagv_din
);

  localparam int unsigned DIN_W = TAG_WIDTH + 1;

  tagv_state_t           state, state_next;
  logic                  cnt_start, cnt_en, cnt_last;
  logic [ADDR_WIDTH-1:0] cnt;
  logic [WAYS-1:0]       we_d;
  logic [ADDR_WIDTH-1:0] waddr_d;
  logic [DIN_W-1:0]      din_d;

  tagv_sweep_cnt #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_sweep_cnt (
    .clk  (clk),
    .rst  (rst),
    .start(cnt_start),
    .en   (cnt_en),
    .count(cnt),
    .last (cnt_last)
  );

  // The write port is registered, so the next-cycle write is decided here.
  // During SWEEP the counter holds the address currently on tagv_waddr,
  // hence the registered address for the following cycle is cnt + 1.
  always_comb begin
    state_next = state;
    cnt_start  = 1'b0;
    cnt_en     = 1'b0;
    we_d       = '0;
    waddr_d    = '0;
    din_d      = '0;
    case (state)
      IDLE: begin
        if (refill_req) begin
          we_d    = WAYS'(1) << refill_way;
          waddr_d = refill_idx;
          din_d   = DIN_W'(tagv_word(TAGV_TAG_MAX'(refill_tag), 1'b1));
        end else if (cacop_req) begin
          we_d    = WAYS'(1) << cacop_way;
          waddr_d = cacop_idx;
        end else if (ibar_req) begin
          state_next = SWEEP;
          cnt_start  = 1'b1;
          we_d       = '1;
        end
      end
      SWEEP: begin
        if (cnt_last) begin
          state_next = ACK;
        end else begin
          cnt_en  = 1'b1;
          we_d    = '1;
          waddr_d = cnt + ADDR_WIDTH'(1);
        end
      end
      ACK: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      tagv_we    <= '0;
      tagv_waddr <= '0;
      tagv_din   <= '0;
    end else begin
      state      <= state_next;
      tagv_we    <= we_d;
      tagv_waddr <= waddr_d;
      tagv_din   <= din_d;
    end
  end

  // Readies are masked by rst so every output reads 0 while reset is held.
  assign refill_ready = ~rst & (state == IDLE);
  assign cacop_ready  = refill_ready & ~refill_req;
  assign busy         = (state == SWEEP);
  assign ibar_ack     = (state == ACK);

endmodule

// File: tb/tb_tagv_write_ctrl.sv
module tb_tagv_write_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        ibar_req;
  logic        ibar_ack;
  logic        refill_req;
  logic [5:0]  refill_idx;
  logic [0:0]  refill_way;
  logic [19:0] refill_tag;
  logic        refill_ready;
  logic        cacop_req;
  logic [5:0]  cacop_idx;
  logic [0:0]  cacop_way;
  logic        cacop_ready;
  logic        busy;
  logic [1:0]  tagv_we;
  logic [5:0]  tagv_waddr;
  logic [20:0] tagv_din;

  // {we, waddr, din} and {ibar_ack, busy, refill_ready, cacop_ready}
  logic [28:0] wr_obs;
  logic [3:0]  st_obs;
  assign wr_obs = {tagv_we, tagv_waddr, tagv_din};
  assign st_obs = {ibar_ack, busy, refill_ready, cacop_ready};

  int n_checks = 0;
  int n_fails  = 0;

  tagv_write_ctrl #(
    .ADDR_WIDTH(6),
    .TAG_WIDTH (20),
    .WAYS      (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .ibar_req    (ibar_req),
    .ibar_ack    (ibar_ack),
    .refill_req  (refill_req),
    .refill_idx  (refill_idx),
    .refill_way  (refill_way),
    .refill_tag  (refill_tag),
    .refill_ready(refill_ready),
    .cacop_req   (cacop_req),
    .cacop_idx   (cacop_idx),
    .cacop_way   (cacop_way),
    .cacop_ready (cacop_ready),
    .busy        (busy),
    .tagv_we     (tagv_we),
    .tagv_waddr  (tagv_waddr),
    .tagv_din    (tagv_din)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no end expected end");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (wr_obs !== 29'h0) begin
      n_fails++; $display("FAIL reset_write: got %h expected %h", wr_obs, 29'h0);
    end
    n_checks++;
    if (st_obs !== 4'b0000) begin
      n_fails++; $display("FAIL reset_status: got %b expected %b", st_obs, 4'b0000);
    end
    rst = 1'b0;
    #1;
    n_checks++;
    if (st_obs !== 4'b0011) begin
      n_fails++; $display("FAIL post_reset_idle: got %b expected %b", st_obs, 4'b0011);
    end
  endtask

  task automatic test_refill();
    refill_req = 1'b1; refill_idx = 6'd5; refill_way = 1'b1; refill_tag = 20'h12345;
    #1;
    n_checks++;
    if (st_obs !== 4'b0010) begin
      n_fails++; $display("FAIL refill_ready: got %b expected %b", st_obs, 4'b0010);
    end
    step();
    refill_req = 1'b0;
    n_checks++;
    if (wr_obs !== {2'b10, 6'd5, 21'h2468B}) begin
      n_fails++; $display("FAIL refill_write: got %h expected %h", wr_obs, {2'b10, 6'd5, 21'h2468B});
    end
    step();
    n_checks++;
    if (wr_obs !== 29'h0) begin
      n_fails++; $display("FAIL refill_single: got %h expected %h", wr_obs, 29'h0);
    end
  endtask

  task automatic test_ibar();
    ibar_req = 1'b1;
    #1;
    n_checks++;
    if (st_obs !== 4'b0011) begin
      n_fails++; $display("FAIL ibar_idle: got %b expected %b", st_obs, 4'b0011);
    end
    step();
    for (int i = 0; i < 64; i++) begin
      n_checks++;
      if (wr_obs !== {2'b11, 6'(i), 21'h0}) begin
        n_fails++; $display("FAIL sweep_write[%0d]: got %h expected %h", i, wr_obs, {2'b11, 6'(i), 21'h0});
      end
      n_checks++;
      if (st_obs !== 4'b0100) begin
        n_fails++; $display("FAIL sweep_status[%0d]: got %b expected %b", i, st_obs, 4'b0100);
      end
      step();
    end
    n_checks++;
    if (st_obs !== 4'b1000) begin
      n_fails++; $display("FAIL ibar_ack: got %b expected %b", st_obs, 4'b1000);
    end
    n_checks++;
    if (wr_obs !== 29'h0) begin
      n_fails++; $display("FAIL ack_no_write: got %h expected %h", wr_obs, 29'h0);
    end
    ibar_req = 1'b0;
    step();
    n_checks++;
    if (st_obs !== 4'b0011) begin
      n_fails++; $display("FAIL after_ack_idle: got %b expected %b", st_obs, 4'b0011);
    end
  endtask

  task automatic test_same_cycle();
    refill_req = 1'b1; refill_idx = 6'd3; refill_way = 1'b0; refill_tag = 20'h00ABC;
    cacop_req  = 1'b1; cacop_idx  = 6'd7; cacop_way  = 1'b1;
    #1;
    n_checks++;
    if (st_obs !== 4'b0010) begin
      n_fails++; $display("FAIL same_ready: got %b expected %b", st_obs, 4'b0010);
    end
    step();
    refill_req = 1'b0;
    #1;
    n_checks++;
    if (st_obs !== 4'b0011) begin
      n_fails++; $display("FAIL cacop_held_ready: got %b expected %b", st_obs, 4'b0011);
    end
    n_checks++;
    if (wr_obs !== {2'b01, 6'd3, 21'h01579}) begin
      n_fails++; $display("FAIL same_refill_write: got %h expected %h", wr_obs, {2'b01, 6'd3, 21'h01579});
    end
    step();
    cacop_req = 1'b0;
    n_checks++;
    if (wr_obs !== {2'b10, 6'd7, 21'h0}) begin
      n_fails++; $display("FAIL same_cacop_write: got %h expected %h", wr_obs, {2'b10, 6'd7, 21'h0});
    end
    step();
    n_checks++;
    if (wr_obs !== 29'h0) begin
      n_fails++; $display("FAIL same_done: got %h expected %h", wr_obs, 29'h0);
    end
  endtask

  task automatic test_back_to_back();
    refill_req = 1'b1; refill_idx = 6'd1; refill_way = 1'b0; refill_tag = 20'hFFFFF;
    step();
    refill_req = 1'b0;
    cacop_req  = 1'b1; cacop_idx = 6'd2; cacop_way = 1'b1;
    n_checks++;
    if (wr_obs !== {2'b01, 6'd1, 21'h1FFFFF}) begin
      n_fails++; $display("FAIL b2b_refill_write: got %h expected %h", wr_obs, {2'b01, 6'd1, 21'h1FFFFF});
    end
    #1;
    n_checks++;
    if (st_obs !== 4'b0011) begin
      n_fails++; $display("FAIL b2b_cacop_ready: got %b expected %b", st_obs, 4'b0011);
    end
    step();
    cacop_req = 1'b0;
    n_checks++;
    if (wr_obs !== {2'b10, 6'd2, 21'h0}) begin
      n_fails++; $display("FAIL b2b_cacop_write: got %h expected %h", wr_obs, {2'b10, 6'd2, 21'h0});
    end
    step();
    n_checks++;
    if (wr_obs !== 29'h0) begin
      n_fails++; $display("FAIL b2b_done: got %h expected %h", wr_obs, 29'h0);
    end
  endtask

  task automatic test_refill_during_sweep();
    ibar_req = 1'b1;
    for (int c = 1; c <= 66; c++) begin
      step();
      if (c == 10) begin
        refill_req = 1'b1; refill_idx = 6'd9; refill_way = 1'b1; refill_tag = 20'h54321;
      end
      if (c == 65) begin
        n_checks++;
        if (ibar_ack !== 1'b1) begin
          n_fails++; $display("FAIL during_sweep_ack: got %b expected %b", ibar_ack, 1'b1);
        end
        ibar_req = 1'b0;
      end
      #1;
      n_checks++;
      if (refill_ready !== (c == 66)) begin
        n_fails++; $display("FAIL during_sweep_ready[%0d]: got %b expected %b", c, refill_ready, (c == 66));
      end
      if (c >= 11 && c <= 64) begin
        n_checks++;
        if (tagv_we !== 2'b11) begin
          n_fails++; $display("FAIL during_sweep_we[%0d]: got %b expected %b", c, tagv_we, 2'b11);
        end
      end
    end
    step();
    refill_req = 1'b0;
    n_checks++;
    if (wr_obs !== {2'b10, 6'd9, 21'h0A8643}) begin
      n_fails++; $display("FAIL deferred_refill_write: got %h expected %h", wr_obs, {2'b10, 6'd9, 21'h0A8643});
    end
    step();
  endtask

  task automatic test_reset_mid_sweep();
    logic ack_seen;
    ibar_req = 1'b1;
    repeat (21) step();
    n_checks++;
    if (wr_obs !== {2'b11, 6'd20, 21'h0}) begin
      n_fails++; $display("FAIL pre_reset_sweep: got %h expected %h", wr_obs, {2'b11, 6'd20, 21'h0});
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if (wr_obs !== 29'h0) begin
      n_fails++; $display("FAIL async_reset_write: got %h expected %h", wr_obs, 29'h0);
    end
    n_checks++;
    if (st_obs !== 4'b0000) begin
      n_fails++; $display("FAIL async_reset_status: got %b expected %b", st_obs, 4'b0000);
    end
    ibar_req = 1'b0;
    step();
    step();
    rst = 1'b0;
    ack_seen = 1'b0;
    for (int c = 0; c < 70; c++) begin
      step();
      if (ibar_ack === 1'b1) ack_seen = 1'b1;
    end
    n_checks++;
    if (ack_seen !== 1'b0) begin
      n_fails++; $display("FAIL aborted_no_ack: got %b expected %b", ack_seen, 1'b0);
    end
    refill_req = 1'b1; refill_idx = 6'd10; refill_way = 1'b0; refill_tag = 20'h00001;
    step();
    refill_req = 1'b0;
    n_checks++;
    if (wr_obs !== {2'b01, 6'd10, 21'h000003}) begin
      n_fails++; $display("FAIL post_abort_refill: got %h expected %h", wr_obs, {2'b01, 6'd10, 21'h000003});
    end
    step();
  endtask

  task automatic test_ibar_cacop();
    int k;
    ibar_req = 1'b1;
    cacop_req = 1'b1; cacop_idx = 6'd12; cacop_way = 1'b1;
    #1;
    n_checks++;
    if (st_obs !== 4'b0011) begin
      n_fails++; $display("FAIL ibar_cacop_ready: got %b expected %b", st_obs, 4'b0011);
    end
    step();
    cacop_req = 1'b0;
    n_checks++;
    if (wr_obs !== {2'b10, 6'd12, 21'h0}) begin
      n_fails++; $display("FAIL ibar_cacop_write: got %h expected %h", wr_obs, {2'b10, 6'd12, 21'h0});
    end
    n_checks++;
    if (busy !== 1'b0) begin
      n_fails++; $display("FAIL ibar_cacop_not_busy: got %b expected %b", busy, 1'b0);
    end
    step();
    n_checks++;
    if (st_obs !== 4'b0100) begin
      n_fails++; $display("FAIL ibar_after_cacop_busy: got %b expected %b", st_obs, 4'b0100);
    end
    n_checks++;
    if (wr_obs !== {2'b11, 6'd0, 21'h0}) begin
      n_fails++; $display("FAIL ibar_after_cacop_first: got %h expected %h", wr_obs, {2'b11, 6'd0, 21'h0});
    end
    k = 0;
    while (ibar_ack !== 1'b1 && k < 100) begin
      step();
      k++;
    end
    n_checks++;
    if (k !== 64) begin
      n_fails++; $display("FAIL ibar_after_cacop_ack_latency: got %0d expected %0d", k, 64);
    end
    ibar_req = 1'b0;
    step();
    n_checks++;
    if (st_obs !== 4'b0011) begin
      n_fails++; $display("FAIL ibar_after_cacop_idle: got %b expected %b", st_obs, 4'b0011);
    end
  endtask

  initial begin
    rst = 1'b1;
    ibar_req = 1'b0;
    refill_req = 1'b0; refill_idx = '0; refill_way = '0; refill_tag = '0;
    cacop_req  = 1'b0; cacop_idx  = '0; cacop_way  = '0;
    test_reset();
    test_refill();
    test_ibar();
    test_same_cycle();
    test_back_to_back();
    test_refill_during_sweep();
    test_reset_mid_sweep();
    test_ibar_cacop();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
